mb_scheduler: RTL and testbench

Frame-level sequencer for the intra-prediction macroblock extractor. It walks macroblock numbers across one frame in raster order, pulses the extractor enable, and waits a fixed extraction latency. It then offers each extracted macroblock to the downstream predictor with a valid/ready handshake, together with neighbour-availability flags. It sits between the frame-control logic (start/abort) and the extractor/predictor pair.

---
 rtl/mb_scheduler.sv | 144 ++++++++++++++
 tb/tb_mb_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_scheduler.sv
// Frame-level macroblock sequencer: raster-walks macroblocks, pulses the extractor, offers results via valid/ready.
// Optional stall counter output is enabled by defining MB_SCHED_STALL_CNT_EN.
module mb_scheduler #(
  parameter int LENGTH          = 1280,
  parameter int WIDTH           = 720,
  parameter int MB_SIZE_L       = 16,
  parameter int MB_SIZE_W       = 16,
  parameter int EXTRACT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        extract_enable,
  output logic [12:0] mbnumber,
  output logic        mb_valid,
  input  logic        mb_ready,
  output logic        top_avail,
  output logic        left_avail,
  output logic        busy,
`ifdef MB_SCHED_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        frame_done
);

  localparam int MB_COLS = LENGTH / MB_SIZE_L;
  localparam int MB_ROWS = WIDTH / MB_SIZE_W;
  localparam int NUM_MB  = MB_COLS * MB_ROWS;
  localparam int COL_W   = (MB_COLS > 1) ? $clog2(MB_COLS) : 1;
  localparam int ROW_W   = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1;
  localparam logic [12:0] LAST_MB  = 13'(NUM_MB - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(EXTRACT_LATENCY - 1);

  if (NUM_MB > 8192 || NUM_MB < 1 || (LENGTH % MB_SIZE_L) != 0 || (WIDTH % MB_SIZE_W) != 0 ||
      !(MB_SIZE_L inside {4, 8, 16}) || !(MB_SIZE_W inside {4, 8, 16}) ||
      EXTRACT_LATENCY < 1 || EXTRACT_LATENCY > 15) begin : g_cfg_err
    $error("mb_scheduler: invalid frame/macroblock configuration");
  end

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OFFER, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       lat_cnt, lat_cnt_n;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic [12:0]      mbn_n;

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    col_n     = col;
    row_n     = row;
    mbn_n     = mbnumber;
    case (state)
      IDLE: begin
        mbn_n = '0;
        col_n = '0;
        row_n = '0;
        if (start) state_n = FETCH;
      end
      FETCH: begin
        lat_cnt_n = LAT_LOAD;
        state_n   = WAIT;
      end
      // Leaving at count 1 puts mb_valid EXTRACT_LATENCY cycles after the enable pulse.
      WAIT: begin
        lat_cnt_n = (lat_cnt != 4'd0) ? lat_cnt - 4'd1 : 4'd0;
        if (lat_cnt <= 4'd1) state_n = OFFER;
      end
      OFFER: begin
        if (mb_ready) begin
          if (mbnumber == LAST_MB) begin
            state_n = DONE;
          end else begin
            mbn_n   = mbnumber + 13'd1;
            state_n = FETCH;
            if (col == COL_W'(MB_COLS - 1)) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
      end
      DONE: begin
        mbn_n   = '0;
        col_n   = '0;
        row_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n   = IDLE;
      lat_cnt_n = '0;
      mbn_n     = '0;
      col_n     = '0;
      row_n     = '0;
    end
  end

  // Outputs are registered from next-state so they align with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      col            <= '0;
      row            <= '0;
      mbnumber       <= '0;
      extract_enable <= 1'b0;
      mb_valid       <= 1'b0;
      top_avail      <= 1'b0;
      left_avail     <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      lat_cnt        <= lat_cnt_n;
      col            <= col_n;
      row            <= row_n;
      mbnumber       <= mbn_n;
      extract_enable <= (state_n == FETCH);
      mb_valid       <= (state_n == OFFER);
      top_avail      <= (row_n != '0);
      left_avail     <= (col_n != '0);
      busy           <= (state_n != IDLE);
      frame_done     <= (state_n == DONE);
    end
  end

`ifdef MB_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (state == IDLE && start && !abort)
      stall_cycles <= '0;
    else if (state == OFFER && !mb_ready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mb_scheduler.sv
// Bench for mb_scheduler: scoreboard of expected (mbnumber, top, left) per handshake plus scenario tasks.
module tb_mb_scheduler;
  localparam int COLS = 80;
  localparam int NMB  = 3600;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mb_ready = 1'b0;
  logic        extract_enable, mb_valid, top_avail, left_avail, busy, frame_done;
  logic [12:0] mbnumber;
`ifdef MB_SCHED_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  mb_scheduler dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .extract_enable(extract_enable), .mbnumber(mbnumber), .mb_valid(mb_valid),
    .mb_ready(mb_ready), .top_avail(top_avail), .left_avail(left_avail),
    .busy(busy),
`ifdef MB_SCHED_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .frame_done(frame_done)
  );

  typedef struct packed {logic [12:0] mbn; logic top; logic left;} exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_got;
  int   tests = 0, fails = 0;
  int   cyc = 0, ee_cnt = 0, fd_cnt = 0, hs_cyc = 0, fd_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: each accepted macroblock is checked against the scoreboard head.
  always @(negedge clk) begin
    if (extract_enable) ee_cnt++;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (mb_valid && mb_ready) begin
      tests++;
      mon_got = {mbnumber, top_avail, left_avail};
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL handshake_unexpected: got mb %0d, expected no handshake", mbnumber);
      end else begin
        mon_e = sb.pop_front();
        if (mon_got !== mon_e) begin
          fails++;
          $display("FAIL handshake_mb: got mb %0d top %0b left %0b, expected mb %0d top %0b left %0b",
                   mon_got.mbn, mon_got.top, mon_got.left, mon_e.mbn, mon_e.top, mon_e.left);
        end
      end
      hs_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int n = 0; n < NMB; n++) begin
      e.mbn  = 13'(n);
      e.top  = (n / COLS) != 0;
      e.left = (n % COLS) != 0;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic do_abort();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({extract_enable, mbnumber, mb_valid, top_avail, left_avail, busy, frame_done} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {extract_enable, mbnumber, mb_valid, top_avail, left_avail, busy, frame_done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || extract_enable !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy %b ee %b, expected 0 0", busy, extract_enable);
    end
  endtask

  task automatic test_timing();
    int t0, te, tv, tm;
    fd_cnt = 0; mb_ready = 1'b1; push_frame();
    tick(); start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    te = -1; tv = -1; tm = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (extract_enable && te < 0) te = cyc;
      if (mb_valid && tv < 0) tv = cyc;
      if (mbnumber == 13'd1 && tm < 0) tm = cyc;
    end
    tests++;
    if (te - t0 !== 1) begin fails++; $display("FAIL timing_enable: got +%0d, expected +1", te - t0); end
    tests++;
    if (tv - t0 !== 3) begin fails++; $display("FAIL timing_valid: got +%0d, expected +3", tv - t0); end
    tests++;
    if (tm - t0 !== 4) begin fails++; $display("FAIL timing_mb1: got +%0d, expected +4", tm - t0); end
    do_abort();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mbnumber !== 13'd0 || mb_valid !== 1'b0 || fd_cnt !== 0) begin
      fails++;
      $display("FAIL timing_abort_idle: got busy %b mb %0d valid %b fd %0d, expected 0 0 0 0",
               busy, mbnumber, mb_valid, fd_cnt);
    end
  endtask

  task automatic test_full_frame();
    int n = 0;
    int h;
    fd_cnt = 0; ee_cnt = 0; mb_ready = 1'b1; push_frame();
    pulse_start();
    while (fd_cnt == 0 && n < 40000) begin @(negedge clk); n++; end
    tests++;
    if (fd_cnt == 0) begin
      fails++;
      $display("FAIL full_frame_timeout: got no frame_done in %0d cycles, expected one", n);
    end
    h = hs_cyc;
    tests++;
    if (fd_cyc !== h + 1) begin fails++; $display("FAIL frame_done_cycle: got %0d, expected %0d", fd_cyc, h + 1); end
    tests++;
    if (ee_cnt !== NMB) begin fails++; $display("FAIL enable_count: got %0d, expected %0d", ee_cnt, NMB); end
    tests++;
    if (sb.size() !== 0) begin fails++; $display("FAIL full_frame_left: got %0d pending, expected 0", sb.size()); end
    // Back-to-back: IDLE reached at h+2 and a start there is accepted.
    push_frame();
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_h2: got %b, expected 0", busy); end
    start = 1'b1;
    tick(); start = 1'b0;
    tests++;
    if (extract_enable !== 1'b1 || mbnumber !== 13'd0 || busy !== 1'b1 || fd_cnt !== 1) begin
      fails++;
      $display("FAIL back_to_back: got ee %b mb %0d busy %b fd %0d, expected 1 0 1 1",
               extract_enable, mbnumber, busy, fd_cnt);
    end
    do_abort();
  endtask

  task automatic test_backpressure_abort();
    int n = 0;
    fd_cnt = 0; mb_ready = 1'b1; push_frame();
    pulse_start();
    while (mbnumber != 13'd5 && n < 200) begin @(negedge clk); n++; end
    tick(); mb_ready = 1'b0;
    n = 0;
    while (!mb_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (mb_valid !== 1'b1 || mbnumber !== 13'd5) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got valid %b mb %0d, expected 1 5", i, mb_valid, mbnumber);
      end
      @(posedge clk); #2;
      if (i < 6) @(negedge clk);
    end
    mb_ready = 1'b1;
    @(negedge clk);
`ifdef MB_SCHED_STALL_CNT_EN
    tests++;
    if (stall_cycles !== 32'd7) begin fails++; $display("FAIL stall_cycles: got %0d, expected 7", stall_cycles); end
`endif
    n = 0;
    while (!(mbnumber == 13'd42 && extract_enable) && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (n >= 500) begin fails++; $display("FAIL reach_mb42: got timeout, expected mb 42 fetch"); end
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || mbnumber !== 13'd0 || mb_valid !== 1'b0 || extract_enable !== 1'b0) begin
      fails++;
      $display("FAIL abort_wait: got busy %b mb %0d valid %b ee %b, expected 0 0 0 0",
               busy, mbnumber, mb_valid, extract_enable);
    end
    sb.delete();
    repeat (5) @(negedge clk);
    tests++;
    if (fd_cnt !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses, expected 0", fd_cnt); end
`ifdef MB_SCHED_STALL_CNT_EN
    tests++;
    if (stall_cycles !== 32'd7) begin fails++; $display("FAIL stall_hold_idle: got %0d, expected 7", stall_cycles); end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mb_ready = 1'b0; push_frame();
    pulse_start();
    while (!mb_valid && n < 20) begin @(negedge clk); n++; end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({extract_enable, mbnumber, mb_valid, top_avail, left_avail, busy, frame_done} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid_offer: got %h, expected 0",
               {extract_enable, mbnumber, mb_valid, top_avail, left_avail, busy, frame_done});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mb_valid !== 1'b0) begin
      fails++;
      $display("FAIL no_resume: got busy %b valid %b, expected 0 0", busy, mb_valid);
    end
`ifdef MB_SCHED_STALL_CNT_EN
    tests++;
    if (stall_cycles !== 32'd0) begin fails++; $display("FAIL stall_reset: got %0d, expected 0", stall_cycles); end
`endif
  endtask

  task automatic test_start_ignored();
    int n = 0;
    fd_cnt = 0; ee_cnt = 0; push_frame();
    pulse_start();
    while (fd_cnt == 0 && n < 60000) begin
      tick();
      mb_ready = ($urandom_range(0, 3) != 0);
      start    = ((n % 997) == 500);
      n++;
    end
    start = 1'b0; mb_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (fd_cnt !== 1) begin fails++; $display("FAIL done_once: got %0d pulses, expected 1", fd_cnt); end
    tests++;
    if (ee_cnt !== NMB) begin fails++; $display("FAIL enable_count_bp: got %0d, expected %0d", ee_cnt, NMB); end
    tests++;
    if (sb.size() !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored_end: got %0d pending busy %b, expected 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_full_frame();
    test_backpressure_abort();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
